// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, reads a 1-cycle-latency BRAM and
// buffers returned words in a 2-entry FIFO for decode. Optional macro: FETCH_ALIGN_CHECK_EN.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clka,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_dout,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        fetch_misalign
);

    logic [31:0] fpc_q, fpc_d;
    logic [1:0]  count_q, count_d;
    logic        inflight_q;
    logic [31:0] inflight_pc_q;
    logic        rd_ptr_q, wr_ptr_q;
    logic [31:0] fifo_pc_q   [0:1];
    logic [31:0] fifo_word_q [0:1];

    logic        pop;
    logic        push;
    logic        issue;
    logic        halted;
    logic [2:0]  occupancy;

    assign instr_valid = (count_q != 2'd0);
    assign pop         = instr_valid & instr_ready;
    assign push        = inflight_q;

    // Words already buffered plus the one on its way back must leave room for a new request.
    assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue     = !reset && !redirect_valid && !halted && (occupancy < 3'd2);

    assign imem_en   = issue;
    assign imem_addr = fpc_q;
    assign instr     = fifo_word_q[rd_ptr_q];
    assign instr_pc  = fifo_pc_q[rd_ptr_q];

`ifdef FETCH_ALIGN_CHECK_EN
    logic halted_q;
    logic misalign_q;
    logic redirect_ok;

    assign redirect_ok = (redirect_pc[1:0] == 2'b00);

    // A misaligned target parks the fetcher until an aligned redirect or reset.
    always_ff @(posedge clka) begin
        if (reset) begin
            halted_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else if (redirect_valid) begin
            halted_q   <= !redirect_ok;
            misalign_q <= !redirect_ok;
        end
    end

    assign halted         = halted_q;
    assign fetch_misalign = misalign_q;
`else
    assign halted         = 1'b0;
    assign fetch_misalign = 1'b0;
`endif

    always_comb begin
        fpc_d = fpc_q;
        if (redirect_valid) begin
`ifdef FETCH_ALIGN_CHECK_EN
            fpc_d = redirect_ok ? redirect_pc : fpc_q;
`else
            fpc_d = redirect_pc & 32'hFFFF_FFFC;
`endif
        end else if (issue) begin
            fpc_d = fpc_q + 32'd4;
        end
    end

    always_comb begin
        count_d = count_q + {1'b0, push} - {1'b0, pop};
        if (redirect_valid) begin
            count_d = 2'd0;
        end
    end

    always_ff @(posedge clka) begin
        if (reset) begin
            fpc_q         <= RESET_PC;
            count_q       <= 2'd0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'd0;
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_pc_q[i]   <= 32'd0;
                fifo_word_q[i] <= 32'd0;
            end
        end else begin
            fpc_q      <= fpc_d;
            count_q    <= count_d;
            inflight_q <= issue;
            if (issue) begin
                inflight_pc_q <= fpc_q;
            end
            // A redirect drops both the buffered words and the response arriving now.
            if (redirect_valid) begin
                rd_ptr_q <= 1'b0;
                wr_ptr_q <= 1'b0;
            end else begin
                if (push) begin
                    fifo_pc_q[wr_ptr_q]   <= inflight_pc_q;
                    fifo_word_q[wr_ptr_q] <= imem_dout;
                    wr_ptr_q              <= ~wr_ptr_q;
                end
                if (pop) begin
                    rd_ptr_q <= ~rd_ptr_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed vector table plus randomized run
// against a queue-based model of issued-but-undelivered fetches. Honours FETCH_ALIGN_CHECK_EN.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;

    logic        clka = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_dout = 32'd0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        fetch_misalign;

    instr_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clka           (clka),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_dout      (imem_dout),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .fetch_misalign (fetch_misalign)
    );

    always #5 clka = ~clka;

    // Synchronous BRAM: word content is a fixed function of its address.
    always @(posedge clka) begin
        if (imem_en) imem_dout <= imem_addr ^ KEY;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: every fetch issued since the last flush and not yet delivered, with its issue cycle.
    typedef struct {
        logic [31:0] pc;
        int          cyc;
    } ent_t;
    ent_t        q[$];
    logic [31:0] m_fpc  = RESET_PC;
    logic        m_halt = 1'b0;
    logic        m_mis  = 1'b0;
    int          cyc    = 0;

    logic        smp_en, smp_valid, smp_mis;
    logic [31:0] smp_addr, smp_pc;

    task automatic step(input logic rst_v, input logic redir_v, input logic [31:0] rpc_v,
                        input logic rdy_v);
        logic exp_valid, exp_en, pop;
        @(negedge clka);
        reset          = rst_v;
        redirect_valid = redir_v;
        redirect_pc    = rpc_v;
        instr_ready    = rdy_v;
        #1;
        smp_en = imem_en; smp_addr = imem_addr; smp_valid = instr_valid;
        smp_pc = instr_pc; smp_mis = fetch_misalign;

        exp_valid = (q.size() > 0) && (q[0].cyc + 2 <= cyc);
        pop       = exp_valid && rdy_v;
        exp_en    = !rst_v && !redir_v && !m_halt && ((q.size() - (pop ? 1 : 0)) < 2);

        chk("instr_valid", {31'd0, instr_valid}, {31'd0, exp_valid});
        if (exp_valid) begin
            chk("instr_pc", instr_pc, q[0].pc);
            chk("instr", instr, q[0].pc ^ KEY);
        end
        chk("imem_en", {31'd0, imem_en}, {31'd0, exp_en});
        if (exp_en) chk("imem_addr", imem_addr, m_fpc);
        chk("fetch_misalign", {31'd0, fetch_misalign}, {31'd0, m_mis});

        if (rst_v) begin
            q.delete();
            m_fpc  = RESET_PC;
            m_halt = 1'b0;
            m_mis  = 1'b0;
        end else begin
            if (pop) begin
                $display("deliver cyc=%0d pc=%h instr=%h", cyc, instr_pc, instr);
                q.delete(0);
            end
            if (redir_v) begin
                q.delete();
`ifdef FETCH_ALIGN_CHECK_EN
                if (rpc_v[1:0] != 2'b00) begin
                    m_halt = 1'b1;
                    m_mis  = 1'b1;
                end else begin
                    m_fpc  = rpc_v;
                    m_halt = 1'b0;
                    m_mis  = 1'b0;
                end
`else
                m_fpc = {rpc_v[31:2], 2'b00};
`endif
            end else if (exp_en) begin
                q.push_back('{pc: m_fpc, cyc: cyc});
                m_fpc = m_fpc + 32'd4;
            end
        end
        cyc++;
    endtask

    typedef struct {
        logic        rst, redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        exp_en;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic        exp_mis;
    } vec_t;
    vec_t tv[$];

    task automatic add(input logic rst, input logic redir, input logic [31:0] rpc, input logic rdy,
                       input logic en, input logic [31:0] addr, input logic vld,
                       input logic [31:0] pc, input logic mis);
        tv.push_back('{rst, redir, rpc, rdy, en, addr, vld, pc, mis});
    endtask

    initial begin
        //  rst rdr rpc           rdy  en  addr          vld pc            mis
        add(1, 0, 32'h0,        1,  0, 32'h0,        0, 32'h0,        0);
        add(0, 0, 32'h0,        1,  1, 32'h0,        0, 32'h0,        0);
        add(0, 0, 32'h0,        1,  1, 32'h4,        0, 32'h0,        0);
        add(0, 0, 32'h0,        1,  1, 32'h8,        1, 32'h0,        0);
        add(0, 0, 32'h0,        1,  1, 32'hC,        1, 32'h4,        0);
        add(0, 0, 32'h0,        0,  0, 32'h0,        1, 32'h8,        0);
        add(0, 0, 32'h0,        0,  0, 32'h0,        1, 32'h8,        0);
        add(0, 0, 32'h0,        1,  1, 32'h10,       1, 32'h8,        0);
        add(0, 0, 32'h0,        1,  1, 32'h14,       1, 32'hC,        0);
        add(0, 0, 32'h0,        1,  1, 32'h18,       1, 32'h10,       0);
        add(0, 1, 32'h100,      1,  0, 32'h0,        1, 32'h14,       0);
        add(0, 0, 32'h0,        1,  1, 32'h100,      0, 32'h0,        0);
        add(0, 0, 32'h0,        1,  1, 32'h104,      0, 32'h0,        0);
        add(0, 0, 32'h0,        1,  1, 32'h108,      1, 32'h100,      0);
        add(0, 1, 32'h102,      1,  0, 32'h0,        1, 32'h104,      0);
`ifdef FETCH_ALIGN_CHECK_EN
        add(0, 0, 32'h0,        1,  0, 32'h0,        0, 32'h0,        1);
        add(0, 1, 32'h200,      1,  0, 32'h0,        0, 32'h0,        1);
        add(0, 0, 32'h0,        1,  1, 32'h200,      0, 32'h0,        0);
        add(1, 1, 32'hFFFF_FFF8, 0, 0, 32'h0,        0, 32'h0,        0);
`else
        add(0, 0, 32'h0,        1,  1, 32'h100,      0, 32'h0,        0);
        add(0, 0, 32'h0,        1,  1, 32'h104,      0, 32'h0,        0);
        add(0, 0, 32'h0,        1,  1, 32'h108,      1, 32'h100,      0);
        add(1, 1, 32'hFFFF_FFF8, 0, 0, 32'h0,        1, 32'h104,      0);
`endif
        add(0, 0, 32'h0,        1,  1, 32'h0,        0, 32'h0,        0);
        add(0, 1, 32'hFFFF_FFF8, 1, 0, 32'h0,        0, 32'h0,        0);
        add(0, 0, 32'h0,        1,  1, 32'hFFFF_FFF8, 0, 32'h0,       0);
        add(0, 0, 32'h0,        1,  1, 32'hFFFF_FFFC, 0, 32'h0,       0);
        add(0, 0, 32'h0,        1,  1, 32'h0,        1, 32'hFFFF_FFF8, 0);
        add(0, 0, 32'h0,        1,  1, 32'h4,        1, 32'hFFFF_FFFC, 0);
        add(0, 0, 32'h0,        1,  1, 32'h8,        1, 32'h0,        0);

        reset = 1'b1;
        repeat (2) @(posedge clka);

        for (int i = 0; i < tv.size(); i++) begin
            step(tv[i].rst, tv[i].redir, tv[i].rpc, tv[i].rdy);
            chk($sformatf("vec%0d_en", i), {31'd0, smp_en}, {31'd0, tv[i].exp_en});
            if (tv[i].exp_en) chk($sformatf("vec%0d_addr", i), smp_addr, tv[i].exp_addr);
            chk($sformatf("vec%0d_valid", i), {31'd0, smp_valid}, {31'd0, tv[i].exp_valid});
            if (tv[i].exp_valid) chk($sformatf("vec%0d_pc", i), smp_pc, tv[i].exp_pc);
            chk($sformatf("vec%0d_mis", i), {31'd0, smp_mis}, {31'd0, tv[i].exp_mis});
            if (i == 0) begin
                chk("reset_instr", instr, 32'd0);
                chk("reset_instr_pc", instr_pc, 32'd0);
            end
        end

        for (int n = 0; n < 600; n++) begin
            logic        r_rst, r_red, r_rdy;
            logic [31:0] r_pc;
            r_rst = ($urandom_range(0, 63) == 0);
            r_red = ($urandom_range(0, 9) == 0);
            r_rdy = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 3))
                0:       r_pc = 32'hFFFF_FFF0 + $urandom_range(0, 15);
                1:       r_pc = $urandom & 32'h0000_0FFC;
                default: r_pc = $urandom;
            endcase
            step(r_rst, r_red, r_pc, r_rdy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
